// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of the single SRAM controller.
// One access in flight at a time; a hung controller is aborted after TIMEOUT cycles.
module sram_port_arbiter #(
   parameter int AW      = 18,
   parameter int DW      = 16,
   parameter int TIMEOUT = 64
) (
   input  logic          CLK0,
   input  logic          reset_n,

   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic [DW-1:0] a_rdata,
   output logic          a_ack,
   output logic          a_err,

   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic [DW-1:0] b_rdata,
   output logic          b_ack,
   output logic          b_err,

   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_rd,
   output logic          mem_wr,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata,

   output logic          owner
);

   localparam int            TW    = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic          last;
   logic          we_q;
   logic [TW-1:0] timer;
   logic          grant_b;

   // Both requesting: hand the grant to whichever port did not win last time.
   function automatic logic pick_b(input logic ra, input logic rb, input logic lst);
      return rb & (~ra | ~lst);
   endfunction

   always_comb begin
      grant_b = pick_b(a_req, b_req, last);
   end

   always_ff @(posedge CLK0) begin
      if (!reset_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         we_q      <= 1'b0;
         timer     <= '0;
         owner     <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         a_rdata   <= '0;
         b_rdata   <= '0;
         a_ack     <= 1'b0;
         b_ack     <= 1'b0;
         a_err     <= 1'b0;
         b_err     <= 1'b0;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         a_err <= 1'b0;
         b_err <= 1'b0;

         case (state)
            // IDLE: arbitrate and launch the access
            IDLE: begin
               if (a_req | b_req) begin
                  owner     <= grant_b;
                  last      <= grant_b;
                  timer     <= '0;
                  if (grant_b) begin
                     mem_addr  <= b_addr;
                     mem_wdata <= b_wdata;
                     we_q      <= b_we;
                     mem_rd    <= ~b_we;
                     mem_wr    <= b_we;
                  end else begin
                     mem_addr  <= a_addr;
                     mem_wdata <= a_wdata;
                     we_q      <= a_we;
                     mem_rd    <= ~a_we;
                     mem_wr    <= a_we;
                  end
                  state <= BUSY;
               end
            end

            // BUSY: hold strobes until the controller answers or the timer expires
            BUSY: begin
               timer <= timer + TW'(1);
               if (mem_ready) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  if (!we_q) begin
                     if (owner) b_rdata <= mem_rdata;
                     else       a_rdata <= mem_rdata;
                  end
                  if (owner) b_ack <= 1'b1;
                  else       a_ack <= 1'b1;
                  state <= DONE;
               end else if (timer == TLAST) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  if (owner) begin
                     b_rdata <= {DW{1'b1}};
                     b_ack   <= 1'b1;
                     b_err   <= 1'b1;
                  end else begin
                     a_rdata <= {DW{1'b1}};
                     a_ack   <= 1'b1;
                     a_err   <= 1'b1;
                  end
                  state <= DONE;
               end
            end

            // DONE: ack is visible for this one cycle; requests are not sampled
            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
